// File: rtl/md_pkg.sv
// Shared constants and state encoding for the MD byte-stream padder.
package md_pkg;

    localparam int         BLOCK_BYTES  = 64;
    localparam int         LEN_BYTE_OFS = 56;
    localparam logic [7:0] PAD_BYTE     = 8'h80;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        EMIT,
        LEN
    } md_pad_state_t;

endpackage

// File: rtl/md_block_padder.sv
// Collects message bytes into 512-bit blocks and appends MD padding
// (0x80 marker, zero fill, 64-bit bit length) for the compression core.
//
// state | meaning
// ------+----------------------------------------------------------
// FILL  | accepting message bytes into the buffer
// PAD   | writing the 0x80 marker, plus the length field if it fits
// EMIT  | block presented to the core, held until blk_ready
// LEN   | writing the length field into an otherwise empty block
module md_block_padder
    import md_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last
);

    localparam int LEN_W = CNT_W + 3;

    md_pad_state_t      state;
    logic [511:0]       buffer;
    logic [5:0]         idx;
    logic [CNT_W-1:0]   cnt;
    logic               last_seen;
    logic               need_len;

    logic               byte_hs;
    logic               blk_hs;
    logic               wr_en;
    logic [7:0]         wr_byte;
    logic               len_en;
    logic               len_fits;
    logic [LEN_W-1:0]   len_bits;
    logic [63:0]        len_field;
    logic [511:0]       lane_buf;
    logic [511:0]       next_buf;

    assign in_ready  = (state == FILL);
    assign blk_valid = (state == EMIT);
    assign blk_data  = buffer;

    assign byte_hs  = in_valid && (state == FILL);
    assign blk_hs   = blk_ready && (state == EMIT);
    assign len_fits = (idx <= 6'(LEN_BYTE_OFS - 1));

    assign wr_en   = byte_hs || (state == PAD);
    assign wr_byte = (state == PAD) ? PAD_BYTE : in_data;
    assign len_en  = ((state == PAD) && len_fits) || (state == LEN);

    // Bit length is the byte count times eight, widened or cut to 64 bits.
    assign len_bits  = {cnt, 3'b000};
    assign len_field = 64'(len_bits);

    always_comb begin
        lane_buf = buffer;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (wr_en && (idx == 6'(k))) begin
                lane_buf[511-8*k -: 8] = wr_byte;
            end
        end
    end

    always_comb begin
        next_buf = lane_buf;
        if (len_en) begin
            next_buf[63:0] = len_field;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            buffer    <= '0;
            idx       <= '0;
            cnt       <= '0;
            last_seen <= 1'b0;
            need_len  <= 1'b0;
            blk_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (byte_hs) begin
                        buffer <= next_buf;
                        idx    <= idx + 6'd1;
                        cnt    <= cnt + CNT_W'(1);
                        if (idx == 6'(BLOCK_BYTES - 1)) begin
                            state     <= EMIT;
                            blk_last  <= 1'b0;
                            last_seen <= in_last;
                        end else if (in_last) begin
                            state <= PAD;
                        end
                    end
                end

                PAD: begin
                    buffer <= next_buf;
                    state  <= EMIT;
                    if (len_fits) begin
                        blk_last <= 1'b1;
                    end else begin
                        blk_last <= 1'b0;
                        need_len <= 1'b1;
                    end
                end

                EMIT: begin
                    if (blk_hs) begin
                        buffer <= '0;
                        idx    <= '0;
                        if (need_len) begin
                            state <= LEN;
                        end else if (last_seen) begin
                            // Message ended exactly on a block boundary: marker opens a new block.
                            last_seen <= 1'b0;
                            state     <= PAD;
                        end else if (blk_last) begin
                            cnt   <= '0;
                            state <= FILL;
                        end else begin
                            state <= FILL;
                        end
                    end
                end

                LEN: begin
                    buffer   <= next_buf;
                    blk_last <= 1'b1;
                    need_len <= 1'b0;
                    state    <= EMIT;
                end

                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_md_block_padder.sv
// Directed bench for md_block_padder: short, boundary-length, full-block,
// backpressure and mid-message reset cases against hand-computed blocks.
module tb_md_block_padder;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0]   msg[$];
    logic [511:0] exp_blk;
    logic [511:0] ahmad_blk;
    int           lat;

    md_block_padder #(.CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] put_byte(input logic [511:0] b, input int k, input logic [7:0] v);
        logic [511:0] r;
        r = b;
        r[511-8*k -: 8] = v;
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) chk("in_ready_timeout", 512'(in_ready), 512'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends msg; the final byte carries in_last only when with_last is set.
    task automatic send_msg(input logic with_last);
        for (int i = 0; i < msg.size(); i++) begin
            send_byte(msg[i], with_last && (i == msg.size() - 1));
        end
    endtask

    task automatic wait_blk(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!blk_valid && cycles < 200);
    endtask

    task automatic take_blk();
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
    endtask

    task automatic load_ahmad();
        msg = '{8'h41, 8'h68, 8'h6D, 8'h61, 8'h64};
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        blk_ready = 1'b0;

        ahmad_blk = '0;
        ahmad_blk[511 -: 48] = 48'h41686D616480;
        ahmad_blk[63:0]      = 64'h28;

        #1;
        chk("rst_in_ready",  512'(in_ready),  512'(1));
        chk("rst_blk_valid", 512'(blk_valid), 512'(0));
        chk("rst_blk_last",  512'(blk_last),  512'(0));
        chk("rst_blk_data",  blk_data,        '0);
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // "Ahmad": single padded block, valid two cycles after last byte
        load_ahmad();
        send_msg(1'b1);
        wait_blk(lat);
        chk("ahmad_lat",  512'(lat),      512'(2));
        chk("ahmad_data", blk_data,       ahmad_blk);
        chk("ahmad_last", 512'(blk_last), 512'(1));
        take_blk();

        // 55 bytes: marker and length share the block
        msg = {};
        for (int i = 0; i < 55; i++) msg.push_back(8'(i));
        send_msg(1'b1);
        exp_blk = '0;
        for (int i = 0; i < 55; i++) exp_blk = put_byte(exp_blk, i, 8'(i));
        exp_blk = put_byte(exp_blk, 55, 8'h80);
        exp_blk[63:0] = 64'h1B8;
        wait_blk(lat);
        chk("b55_lat",  512'(lat),      512'(2));
        chk("b55_data", blk_data,       exp_blk);
        chk("b55_last", 512'(blk_last), 512'(1));
        take_blk();

        // 56 bytes: length spills into a second block
        msg = {};
        for (int i = 0; i < 56; i++) msg.push_back(8'(i));
        send_msg(1'b1);
        exp_blk = '0;
        for (int i = 0; i < 56; i++) exp_blk = put_byte(exp_blk, i, 8'(i));
        exp_blk = put_byte(exp_blk, 56, 8'h80);
        wait_blk(lat);
        chk("b56_lat1",  512'(lat),      512'(2));
        chk("b56_data1", blk_data,       exp_blk);
        chk("b56_last1", 512'(blk_last), 512'(0));
        take_blk();
        exp_blk = '0;
        exp_blk[63:0] = 64'h1C0;
        wait_blk(lat);
        chk("b56_lat2",  512'(lat),      512'(2));
        chk("b56_data2", blk_data,       exp_blk);
        chk("b56_last2", 512'(blk_last), 512'(1));
        take_blk();

        // 64 bytes of 0xFF: full block, then marker + length block
        msg = {};
        for (int i = 0; i < 64; i++) msg.push_back(8'hFF);
        send_msg(1'b1);
        wait_blk(lat);
        chk("b64_lat1",  512'(lat),      512'(1));
        chk("b64_data1", blk_data,       {64{8'hFF}});
        chk("b64_last1", 512'(blk_last), 512'(0));
        take_blk();
        exp_blk = '0;
        exp_blk = put_byte(exp_blk, 0, 8'h80);
        exp_blk[63:0] = 64'h200;
        wait_blk(lat);
        chk("b64_lat2",  512'(lat),      512'(2));
        chk("b64_data2", blk_data,       exp_blk);
        chk("b64_last2", 512'(blk_last), 512'(1));
        take_blk();

        // Backpressure: block held for 10 cycles, then a repeat message
        load_ahmad();
        send_msg(1'b1);
        wait_blk(lat);
        chk("hold_lat", 512'(lat), 512'(2));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_data",     blk_data,        ahmad_blk);
            chk("hold_valid",    512'(blk_valid), 512'(1));
            chk("hold_in_ready", 512'(in_ready),  512'(0));
        end
        take_blk();
        load_ahmad();
        send_msg(1'b1);
        wait_blk(lat);
        chk("rep_lat",  512'(lat),      512'(2));
        chk("rep_data", blk_data,       ahmad_blk);
        chk("rep_last", 512'(blk_last), 512'(1));
        take_blk();

        // Reset after 20 bytes discards the partial block and count
        msg = {};
        for (int i = 0; i < 20; i++) msg.push_back(8'(8'hA0 + i));
        send_msg(1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    512'(blk_valid), 512'(0));
        chk("mid_rst_in_ready", 512'(in_ready),  512'(1));
        chk("mid_rst_data",     blk_data,        '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_ahmad();
        send_msg(1'b1);
        wait_blk(lat);
        chk("post_rst_lat",  512'(lat),      512'(2));
        chk("post_rst_data", blk_data,       ahmad_blk);
        chk("post_rst_last", 512'(blk_last), 512'(1));
        take_blk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/md_block_padder.md
# md_block_padder

Byte-stream front end for the MD4-style three-stage compression datapath. It accepts a message one byte at a time, applies MD padding (0x80 marker, zero fill, 64-bit bit-length field) and hands out complete 512-bit blocks in the exact `M` layout the stage1/stage2/stage3 chain consumes. It sits between the message source and the compression core, and uses a valid/ready handshake on both sides.

## Interface
- `CNT_W`, default 32: width of the internal byte counter. Messages wrap modulo 2^CNT_W bytes.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the block can take a byte.
- `in_data` input 8: message byte.
- `in_last` input 1: qualifies `in_data` as the final byte of the message. Every message is at least 1 byte; empty messages are not supported.
- `blk_valid` output 1: `blk_data` holds a complete block.
- `blk_ready` input 1: the core takes the block.
- `blk_data` output 512: the block. Byte k sits at bits [511-8k -: 8]. The bit-length field sits at [63:0], stored as an unsigned value.
- `blk_last` output 1: this is the final block of the message.

## Operation
- States:
  - FILL: `in_ready`=1.
  - PAD: one cycle.
  - EMIT: `blk_valid`=1.
  - LEN: one cycle.
- Registers:
  - 512-bit buffer.
  - 6-bit write index `idx`.
  - CNT_W-bit byte count `cnt`.
  - `last_seen` flag.
- The buffer is zeroed whenever a new block starts, so zero fill needs no extra cycles.
- FILL, on each byte handshake:
  - write the byte at `idx`, then increment `idx` and `cnt`.
  - If `idx` was 63: go to EMIT with `blk_last`=0. If `in_last` is also set, set `last_seen`.
  - Else if `in_last`: go to PAD.
- PAD:
  - write 0x80 at `idx`.
  - If `idx` ≤ 55: write the length field in the same cycle, go to EMIT with `blk_last`=1.
  - Else: go to EMIT with `blk_last`=0 and set a `need_len` flag.
- EMIT:
  - hold `blk_data` and `blk_last` stable until `blk_ready`.
  - On the handshake, clear the buffer and set `idx`=0, then take the first matching branch:
    - if `need_len`: go to LEN.
    - else if `last_seen`: go to PAD, with the marker at byte 0.
    - else if `blk_last`=1: clear `cnt` and go to FILL.
    - else: go to FILL.
- LEN: write the length field, go to EMIT with `blk_last`=1, clear `need_len`.
- Length field = {cnt, 3'b000}, zero-extended to 64 bits, placed in [63:0].
- Byte handshakes occur only in FILL, and block handshakes only in EMIT, so the two can never collide.

## Timing
- Reset values:
  - state FILL, so `in_ready`=1.
  - `blk_valid`=0, `blk_last`=0.
  - `blk_data`=0, `idx`=0, `cnt`=0.
  - all flags cleared.
- Asserting reset mid-message discards the partial block and the count. `blk_valid` drops immediately, asynchronously.
- Latency, message ending at byte position ≤ 55 (cycle N is the handshake of the last byte): PAD at N+1, `blk_valid` at N+2.
- Latency, 64th byte of a block accepted at N: `blk_valid` at N+1.
- After a block handshake at cycle M:
  - LEN path: next block valid at M+2.
  - PAD path: next block valid at M+2.
  - FILL path: `in_ready`=1 at M+1.
- Throughput: one byte per cycle while filling.
- Backpressure holds the block indefinitely with no loss. `in_ready` stays 0 throughout.
- All outputs are registered or decoded from state; there are no combinational paths from input to output.

## Structure
- Shared package `md_pkg` holds:
  - `BLOCK_BYTES`=64
  - `LEN_BYTE_OFS`=56
  - `PAD_BYTE`=8'h80
  - state enum `md_pad_state_t` (FILL, PAD, EMIT, LEN)
- Single module; no sub-module. Byte-lane write and length insertion are local always blocks.

## Test plan
- Message 41 68 6D 61 64 ("Ahmad", `in_last` on 0x64) → one block, `blk_data`=512'h41686D6164_80 followed by zeros, with [63:0]=0x28. `blk_last`=1, `blk_valid` 2 cycles after the last byte.
- 55 bytes 0x00..0x36 → single block: byte 55=0x80, [63:0]=0x1B8, `blk_last`=1.
- 56 bytes 0x00..0x37:
  - block 1: bytes 0..55 as sent, byte 56=0x80, rest zero, `blk_last`=0.
  - block 2: all zero except [63:0]=0x1C0, `blk_last`=1.
- 64 bytes 0xFF:
  - block 1: all 0xFF, `blk_last`=0.
  - block 2: byte 0=0x80, [63:0]=0x200, `blk_last`=1.
- "Ahmad" with `blk_ready` low for 10 cycles → `blk_data` stable and `in_ready`=0 for the whole hold. A second "Ahmad" sent right after the handshake yields an identical block (`cnt` was cleared).
- `rst_n` pulsed low after 20 bytes → `blk_valid`=0, `in_ready`=1. A following "Ahmad" reproduces the first scenario exactly.
